// File: rtl/rv32i_types.sv
// Shared RV32I load/store encodings plus the access-unit state and error types.
package rv32i_types;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    MAU_IDLE,
    MAU_ACCESS,
    MAU_RESP
  } mau_state_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_MISALIGNED = 2'd1,
    ERR_TIMEOUT    = 2'd2,
    ERR_ILLEGAL    = 2'd3
  } mau_err_t;

  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    if (write) return f3 < 3'd3;
    return (f3 != 3'd3) && (f3 < 3'd6);
  endfunction

  // Low two funct3 bits give the access size for both loads and stores.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables, store-data shifting, load extraction/extension.
module mem_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_enable,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;
  logic [3:0]  be_base;

  always_comb begin
    shifted  = rdata >> {offset, 3'b000};
    wdata_sh = wdata << {offset, 3'b000};
    case (funct3[1:0])
      2'b00:   be_base = 4'b0001;
      2'b01:   be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
    byte_enable = be_base << offset;
    case (load_funct3_t'(funct3))
      F3_LB:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  rdata_ext = {24'd0, shifted[7:0]};
      F3_LHU:  rdata_ext = {16'd0, shifted[15:0]};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: request latch, memory handshake FSM with timeout,
// and registered completion with error code.
module mem_access_unit
  import rv32i_types::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT - 1);

  mau_state_t    state_q, state_d;
  mau_err_t      err_q, err_d;
  logic          write_q, write_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;
  logic        in_access;

  mem_align u_align (
    .funct3      (funct3_q),
    .offset      (addr_q[1:0]),
    .wdata       (wdata_q),
    .rdata       (mem_rdata),
    .byte_enable (al_be),
    .wdata_sh    (al_wdata),
    .rdata_ext   (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MAU_IDLE;
      err_q    <= ERR_NONE;
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      MAU_IDLE: if (req_valid) begin
        write_d  = req_write;
        funct3_d = req_funct3;
        addr_d   = req_addr;
        wdata_d  = req_wdata;
        cnt_d    = '0;
        if (!f3_legal(req_write, req_funct3)) begin
          state_d = MAU_RESP;
          err_d   = ERR_ILLEGAL;
          rdata_d = 32'd0;
        end else if (f3_misaligned(req_funct3, req_addr[1:0])) begin
          state_d = MAU_RESP;
          err_d   = ERR_MISALIGNED;
          rdata_d = 32'd0;
        end else begin
          state_d = MAU_ACCESS;
        end
      end
      // A response arriving on the limit cycle still counts as success.
      MAU_ACCESS: if (mem_resp) begin
        state_d = MAU_RESP;
        err_d   = ERR_NONE;
        rdata_d = write_q ? 32'd0 : al_rdata;
      end else if (cnt_q == CNT_LIM) begin
        state_d = MAU_RESP;
        err_d   = ERR_TIMEOUT;
        rdata_d = 32'd0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      MAU_RESP: state_d = MAU_IDLE;
      default:  state_d = MAU_IDLE;
    endcase
  end

  always_comb begin
    in_access       = (state_q == MAU_ACCESS);
    req_ready       = (state_q == MAU_IDLE);
    rsp_valid       = (state_q == MAU_RESP);
    rsp_rdata       = rdata_q;
    rsp_err         = err_q;
    mem_read        = in_access && !write_q;
    mem_write       = in_access && write_q;
    mem_address     = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_byte_enable = in_access ? al_be : 4'd0;
    mem_wdata       = (in_access && write_q) ? al_wdata : 32'd0;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store access unit between the RV32I multicycle datapath and the word-addressed memory port. Accepts one load or store request at a time from the datapath/control side. Drives the memory handshake (mem_read/mem_write/mem_resp) and aligns store data with byte enables. Returns extracted, sign- or zero-extended load data, and flags misaligned, illegal-funct3 and timed-out accesses.

## Interface
- TIMEOUT, 1023: max cycles a strobe is held waiting for mem_resp before aborting; ≥1.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present; sampled only when req_ready=1
- req_ready  out  1  unit idle, can accept
- req_write  in  1  1=store, 0=load
- req_funct3  in  3  RV32I load/store funct3 (lb/lh/lw/lbu/lhu; sb/sh/sw)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, value in low bits
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  2  0 ok, 1 misaligned, 2 timeout, 3 illegal funct3
- mem_address  out  32  {addr[31:2],2'b00}
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_byte_enable  out  4  active lanes
- mem_wdata  out  32  lane-shifted store data
- mem_rdata  in  32  read word
- mem_resp  in  1  memory done

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, latch write, funct3, addr, wdata.
  - Illegal funct3 (load 3/6/7, store ≥3) → RESP, err=3.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) → RESP, err=1.
  - Otherwise → ACCESS.
  - Errors never assert mem_read/mem_write.
- ACCESS: exactly one of mem_read/mem_write high; address, byte enables and wdata held stable.
  - mem_resp=1 → RESP, err=0.
  - For loads, extract from mem_rdata in the same cycle into rsp_rdata.
  - No resp, and timeout counter = TIMEOUT-1 → RESP, err=2.
- RESP: rsp_valid=1 for one cycle → IDLE.
- Byte enables:
  - sb: 4'b0001<<addr[1:0]
  - sh: 4'b0011<<addr[1:0]
  - sw: 4'b1111
  - Loads: same pattern per size.
- mem_wdata = wdata << (8·addr[1:0]).
- Load data, with byte offset k=addr[1:0]:
  - lb/lbu: mem_rdata[8k+7:8k], sign-/zero-extended.
  - lh/lhu: mem_rdata[8k+15:8k], sign-/zero-extended.
  - lw: whole word.
- mem_resp outside ACCESS is ignored.

## Timing
- Reset: state IDLE; req_ready=1; all other outputs 0; counter 0.
- rst asserted in any state takes effect at that edge. Strobes are low the following cycle, and no rsp_valid is issued for the aborted request.
- Request accepted at edge 0. Strobes are registered and high from cycle 1. If mem_resp is first seen in cycle k (k≥1), strobes drop in cycle k+1 and rsp_valid is high in cycle k+1.
- Minimum latency, accept to rsp_valid: 2 cycles. Error paths: 1 cycle after acceptance.
- Timeout counter clears on entering ACCESS and increments each ACCESS cycle without resp. If mem_resp and the counter limit coincide in the same cycle, mem_resp wins (err=0).
- req_ready=0 in ACCESS and RESP. A new request can be accepted at the earliest in the cycle after rsp_valid.
- rsp_rdata and rsp_err hold their values until the next completion.

## Structure
- The rv32i_types package supplies load_funct3_t and store_funct3_t.
- Add to the package: the mau_state_t enum, and a mau_err_t enum (none, misaligned, timeout, illegal).
- One combinational sub-module, mem_align, containing:
  - byte-enable generation;
  - store-data lane shifting;
  - load extraction and extension.
- The FSM, latches and counter live in mem_access_unit.

## Test plan
- lw 0x00000100, mem_resp in third ACCESS cycle with mem_rdata 0xDEADBEEF:
  - mem_read high cycles 1–3, mem_address 0x100, be 4'b1111.
  - rsp_valid in cycle 4, rsp_rdata 0xDEADBEEF, err 0.
- lb 0x00000203, mem_rdata 0x80123456 → be 4'b1000, rsp_rdata 0xFFFFFF80. Same access as lbu → 0x00000080.
- sh 0x00000302, wdata 0x1234ABCD → mem_write, mem_address 0x300, be 4'b1100, mem_wdata 0xABCD0000; rsp_rdata 0.
- lw 0x00000102 → no strobe ever; rsp_valid 1 cycle after acceptance; err 1. Load funct3=3 → err 3.
- TIMEOUT=8, mem_resp never asserted → mem_read high exactly 8 cycles, then rsp_valid with err 2.
- Assert rst during ACCESS → strobes 0 next cycle, req_ready 1, no rsp_valid. A subsequent sw completes normally.
